i2c_frame_master: RTL
=====================

Name: i2c_frame_master

Overview:
Host-side counterpart of the PWM device's slave frame bridge. Accepts one register transaction (16-bit write or 16-bit read) and sequences it into byte-level commands for an I2C byte engine (PHY). Frame formats match the device exactly:
- Write: START, dev+W, reg, data[15:8], data[7:0], STOP.
- Read: START, dev+W, reg, repeated START, dev+R, data[7:0], data[15:8], STOP.
Sits between a CPU/test-host register port and the bit-level I2C master PHY.

Parameters:
TIMEOUT_CYCLES, 50000, max cycles to wait for phy_done_i per command (TIMEOUT_EN only)
TIMEOUT_W, 16, width of timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  transaction request
req_ready_o  out  1  high only in IDLE; a request is accepted when valid and ready are both high
req_rw_i  in  1  0 = write, 1 = read
req_dev_addr_i  in  7  7-bit device address
req_reg_addr_i  in  8  register address
req_wdata_i  in  16  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  16  read data; holds until the next read completes
rsp_err_o  out  1  NACK or timeout; valid with rsp_valid_o
phy_cmd_o  out  2  CMD_START / CMD_WRITE / CMD_READ / CMD_STOP
phy_cmd_valid_o  out  1  command valid
phy_cmd_ready_i  in  1  PHY accepts command
phy_tx_data_o  out  8  byte for CMD_WRITE
phy_mack_o  out  1  for CMD_READ: 1 = master sends ACK, 0 = NACK
phy_done_i  in  1  one-cycle pulse when the accepted command has finished on the bus
phy_ack_i  in  1  slave ACK for CMD_WRITE; sampled with phy_done_i
phy_rx_data_i  in  8  received byte for CMD_READ; sampled with phy_done_i

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1. State = IDLE, request latches cleared, rsp_rdata_o = 0.
- On accept, the request is latched: rw, dev, reg, wdata.
- States: IDLE, START, DEV_W, REG, WD_HI, WD_LO, RSTART, DEV_R, RD_LO, RD_HI, STOP, RESP.
- Each command state has two phases:
  - ISSUE: phy_cmd_valid_o = 1 with stable cmd/data until phy_cmd_ready_i.
  - WAIT: phy_cmd_valid_o = 0 until phy_done_i.
  - The state advances on phy_done_i.
- Latency: request accepted at cycle N -> phy_cmd_valid_o = 1 with CMD_START at N+1.
- Command bytes:
  - DEV_W sends {dev, 1'b0}.
  - DEV_R sends {dev, 1'b1}.
  - REG sends reg.
  - WD_HI sends wdata[15:8]; WD_LO sends wdata[7:0].
- Read bytes:
  - RD_LO uses phy_mack_o = 1 and captures rdata[7:0].
  - RD_HI uses phy_mack_o = 0 and captures rdata[15:8].
- Sequence after REG: on a write go to WD_HI; on a read go to RSTART, which issues CMD_START.
- NACK handling: if phy_ack_i = 0 at phy_done_i in DEV_W, REG, WD_HI, WD_LO or DEV_R, set the error flag, skip the remaining bytes and go to STOP. A STOP is always issued.
- STOP done -> RESP: rsp_valid_o = 1 for one cycle with rsp_err_o; the next cycle is IDLE.
- On an error read, rsp_rdata_o is not updated.
- phy_done_i in an ISSUE phase or in IDLE is ignored.
- phy_cmd_ready_i and phy_done_i arriving in the same cycle: treat as accept only; the done is ignored (the PHY must not do this).
- req_valid_i while busy: req_ready_o = 0, nothing is latched.
- Reset mid-transaction: immediate return to IDLE, phy_cmd_valid_o drops asynchronously. The PHY must share the same reset.

Optional Feature:
I2C_MASTER_TIMEOUT_EN
- Defined:
  - A counter starts at every WAIT-phase entry and clears on phy_done_i.
  - If it reaches TIMEOUT_CYCLES, set the error flag and go to RESP directly, with no STOP (the bus is assumed hung).
  - The counter is not used in ISSUE phases.
- Undefined: no counter; the block waits indefinitely for phy_done_i.

Decomposition:
- Shared package i2c_pkg:
  - phy command encoding: CMD_START = 0, CMD_WRITE = 1, CMD_READ = 2, CMD_STOP = 3;
  - state encoding localparams;
  - RW_WRITE / RW_READ constants.
- Single module; no sub-module. The timeout counter stays inline.

Test Plan:
- Write dev 0x40, reg 0x06, data 0xA55A, PHY model always ACKs. Required PHY commands: START, W 0x80, W 0x06, W 0xA5, W 0x5A, STOP. Required response: rsp_valid with err = 0.
- Read dev 0x40, reg 0x08, PHY returns 0x34 then 0x12. Required PHY commands: START, W 0x80, W 0x08, START, W 0x81, R (mack = 1), R (mack = 0), STOP. Required response: rsp_rdata = 0x1234, err = 0.
- Device-address NACK on a write. Required PHY commands: START, W 0x80, STOP only. Required response: err = 1.
- PHY holds cmd_ready low for 20 cycles on each command. Required: cmd/data stable throughout, no duplicate issue, same final result as the first test.
- Assert rst_n_i low during WD_HI, then release and send a new read request. Required: outputs return to reset values, req_ready_o = 1, the new transaction completes normally.
- TIMEOUT_EN defined with TIMEOUT_CYCLES = 100, PHY never pulses done after START. Required: rsp_valid with err = 1 exactly 100 cycles after the START accept, no STOP issued.

Source files
------------

// File: rtl/i2c_pkg.sv
//==============================================================================
// i2c_pkg: shared encodings for the I2C frame master (PHY commands, states, rw).
// Rev 1.0
//==============================================================================
`default_nettype none

package i2c_pkg;

   localparam logic [1:0] CMD_START = 2'd0;
   localparam logic [1:0] CMD_WRITE = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_STOP  = 2'd3;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_START  = 4'd1,
      S_DEV_W  = 4'd2,
      S_REG    = 4'd3,
      S_WD_HI  = 4'd4,
      S_WD_LO  = 4'd5,
      S_RSTART = 4'd6,
      S_DEV_R  = 4'd7,
      S_RD_LO  = 4'd8,
      S_RD_HI  = 4'd9,
      S_STOP   = 4'd10,
      S_RESP   = 4'd11
   } state_t;

   typedef enum logic {
      PH_ISSUE = 1'b0,
      PH_WAIT  = 1'b1
   } phase_t;

endpackage

`default_nettype wire

// File: rtl/i2c_frame_master.sv
//==============================================================================
// i2c_frame_master: sequences one 16-bit register write/read into I2C byte commands.
// Rev 1.0 -- optional macro: I2C_MASTER_TIMEOUT_EN (per-command done timeout)
//==============================================================================
`default_nettype none

module i2c_frame_master
   import i2c_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TIMEOUT_W      = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_rw_i,
   input  logic [6:0]  req_dev_addr_i,
   input  logic [7:0]  req_reg_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [1:0]  phy_cmd_o,
   output logic        phy_cmd_valid_o,
   input  logic        phy_cmd_ready_i,
   output logic [7:0]  phy_tx_data_o,
   output logic        phy_mack_o,
   input  logic        phy_done_i,
   input  logic        phy_ack_i,
   input  logic [7:0]  phy_rx_data_i
);

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic        err_q, err_d;
   logic        rw_q;
   logic [6:0]  dev_q;
   logic [7:0]  reg_q;
   logic [15:0] wdata_q;
   logic [15:0] rx_q;
   logic [15:0] rdata_q;

   logic accept;
   logic cmd_state;
   logic done_evt;
   logic nack;
   logic timeout;

   assign req_ready_o     = (state_q == S_IDLE);
   assign accept          = req_valid_i && req_ready_o;
   assign cmd_state       = (state_q != S_IDLE) && (state_q != S_RESP);
   assign phy_cmd_valid_o = cmd_state && (phase_q == PH_ISSUE);
   assign done_evt        = cmd_state && (phase_q == PH_WAIT) && phy_done_i;
   assign nack            = !phy_ack_i && (state_q inside {S_DEV_W, S_REG, S_WD_HI, S_WD_LO, S_DEV_R});
   assign rsp_valid_o     = (state_q == S_RESP);
   assign rsp_err_o       = rsp_valid_o && err_q;
   assign rsp_rdata_o     = rdata_q;

`ifdef I2C_MASTER_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wait_cnt_q;

   // Counter restarts from zero on every WAIT entry because it is held clear in ISSUE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt_q <= '0;
      end else if ((phase_q == PH_WAIT) && !phy_done_i) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
         wait_cnt_q <= '0;
      end
   end

   assign timeout = cmd_state && (phase_q == PH_WAIT) && !phy_done_i &&
                    (wait_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Command decode depends only on state and latched request, so it stays
   // stable for the whole ISSUE phase.
   always_comb begin
      phy_cmd_o     = CMD_START;
      phy_tx_data_o = '0;
      phy_mack_o    = 1'b0;
      case (state_q)
         S_START, S_RSTART: phy_cmd_o = CMD_START;
         S_DEV_W: begin
            phy_cmd_o     = CMD_WRITE;
            phy_tx_data_o = {dev_q, 1'b0};
         end
         S_REG: begin
            phy_cmd_o     = CMD_WRITE;
            phy_tx_data_o = reg_q;
         end
         S_WD_HI: begin
            phy_cmd_o     = CMD_WRITE;
            phy_tx_data_o = wdata_q[15:8];
         end
         S_WD_LO: begin
            phy_cmd_o     = CMD_WRITE;
            phy_tx_data_o = wdata_q[7:0];
         end
         S_DEV_R: begin
            phy_cmd_o     = CMD_WRITE;
            phy_tx_data_o = {dev_q, 1'b1};
         end
         S_RD_LO: begin
            phy_cmd_o  = CMD_READ;
            phy_mack_o = 1'b1;
         end
         S_RD_HI:  phy_cmd_o = CMD_READ;
         S_STOP:   phy_cmd_o = CMD_STOP;
         default:  ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               phase_d = PH_ISSUE;
               err_d   = 1'b0;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: begin
            if (phase_q == PH_ISSUE) begin
               // A done coincident with ready is deliberately ignored here.
               if (phy_cmd_ready_i) begin
                  phase_d = PH_WAIT;
               end
            end else if (phy_done_i) begin
               phase_d = PH_ISSUE;
               if (nack) begin
                  err_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  case (state_q)
                     S_START:  state_d = S_DEV_W;
                     S_DEV_W:  state_d = S_REG;
                     S_REG:    state_d = (rw_q == RW_READ) ? S_RSTART : S_WD_HI;
                     S_WD_HI:  state_d = S_WD_LO;
                     S_WD_LO:  state_d = S_STOP;
                     S_RSTART: state_d = S_DEV_R;
                     S_DEV_R:  state_d = S_RD_LO;
                     S_RD_LO:  state_d = S_RD_HI;
                     S_RD_HI:  state_d = S_STOP;
                     S_STOP:   state_d = S_RESP;
                     default:  state_d = S_IDLE;
                  endcase
               end
            end else if (timeout) begin
               // Bus presumed hung: report without attempting a STOP.
               err_d   = 1'b1;
               state_d = S_RESP;
               phase_d = PH_ISSUE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         phase_q <= PH_ISSUE;
         err_q   <= 1'b0;
         rw_q    <= RW_WRITE;
         dev_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         err_q   <= err_d;
         if (accept) begin
            rw_q    <= req_rw_i;
            dev_q   <= req_dev_addr_i;
            reg_q   <= req_reg_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (done_evt && (state_q == S_RD_LO)) begin
            rx_q[7:0] <= phy_rx_data_i;
         end
         if (done_evt && (state_q == S_RD_HI)) begin
            rx_q[15:8] <= phy_rx_data_i;
         end
         // Read data is published only when a read finishes cleanly.
         if (done_evt && (state_q == S_STOP) && (rw_q == RW_READ) && !err_q) begin
            rdata_q <= rx_q;
         end
      end
   end

endmodule

`default_nettype wire
